// File: rtl/mealy_mac_bank.sv
// rtl/mealy_mac_bank.sv - multi-channel Mealy multiply-accumulate bank
//
// Holds CHANNELS signed accumulators. Each accepted beat adds x*y to acc[in_chan].
// The same beat reports the accumulator value it found before the update.
// A clr_all pulse starts a sweep that zeroes one accumulator per cycle.
//
// Optional feature macro: MEALY_MAC_SAT_EN
//   defined   - accumulation saturates, and the out_sat port is added
//   undefined - two's-complement wrap at ACC_W bits
//
// Ports:
//   system1000      clock, rising edge
//   system1000_rst  asynchronous reset, active high
//   in_valid/in_ready  beat handshake; a beat is accepted when both are high
//   in_chan         target channel; values >= CHANNELS are accepted and dropped
//   in_x, in_y      signed operands
//   in_clr          with a beat: restart the channel, acc <= x*y
//   clr_all         pulse: start a sweep that clears every accumulator
//   out_valid       one-cycle pulse per processed beat
//   out_chan        channel of the reported value
//   out_acc         accumulator value before this beat's update
//   out_sat         (MEALY_MAC_SAT_EN only) this beat's update saturated
module mealy_mac_bank #(
    parameter int WIDTH    = 9,
    parameter int ACC_W    = 24,
    parameter int CHANNELS = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    system1000,
    input  logic                    system1000_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CW-1:0]           in_chan,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic                    in_clr,
    input  logic                    clr_all,
    output logic                    out_valid,
    output logic [CW-1:0]           out_chan,
`ifdef MEALY_MAC_SAT_EN
    output logic                    out_sat,
`endif
    output logic signed [ACC_W-1:0] out_acc
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CW:0]      CH_LIMIT = CW'(CHANNELS) == '0 ? {1'b1, {CW{1'b0}}} : (CW + 1)'(CHANNELS);
    localparam logic [CW-1:0]    LAST_IDX = CW'(CHANNELS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                  state;
    logic [CW-1:0]           idx;
    logic signed [ACC_W-1:0] acc [CHANNELS];

    logic                    accept;
    logic                    in_range;
    logic signed [ACC_W-1:0] old_acc;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] base;
    logic [ACC_W:0]          sum_w;
    logic signed [ACC_W-1:0] new_acc;
    logic                    sat_hit;

    always_comb begin
        accept   = in_valid & in_ready;
        in_range = ({1'b0, in_chan} < CH_LIMIT);
        old_acc  = in_range ? acc[in_chan] : '0;
        // Operands are widened before multiplying so the full signed product is kept.
        prod     = PW'(in_x) * PW'(in_y);
        prod_ext = ACC_W'(prod);
        base     = in_clr ? '0 : old_acc;
        // One guard bit: overflow shows as the top two bits disagreeing.
        sum_w    = {base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext};
        sat_hit  = 1'b0;
        new_acc  = sum_w[ACC_W-1:0];
`ifdef MEALY_MAC_SAT_EN
        sat_hit  = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        if (sat_hit) begin
            new_acc = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_acc   <= '0;
`ifdef MEALY_MAC_SAT_EN
            out_sat   <= 1'b0;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            // in_ready is low throughout SWEEP, so beat writes and sweep writes never collide.
            if (accept && in_range) begin
                acc[in_chan] <= new_acc;
                out_valid    <= 1'b1;
                out_chan     <= in_chan;
                out_acc      <= old_acc;
`ifdef MEALY_MAC_SAT_EN
                out_sat      <= sat_hit;
`endif
            end
            case (state)
                IDLE: begin
                    if (clr_all) begin
                        state    <= SWEEP;
                        idx      <= '0;
                        in_ready <= 1'b0;
                    end
                end
                SWEEP: begin
                    acc[idx] <= '0;
                    if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    logic unused_sat;
    assign unused_sat = sat_hit;

endmodule

// File: tb/tb_mealy_mac_bank.sv
// tb/tb_mealy_mac_bank.sv - directed self-checking bench for mealy_mac_bank
module tb_mealy_mac_bank;

    localparam int W  = 9;
    localparam int A  = 18;
    localparam int C  = 3;
    localparam int CW = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [CW-1:0]       in_chan = '0;
    logic signed [W-1:0] in_x = '0;
    logic signed [W-1:0] in_y = '0;
    logic                in_clr = 1'b0;
    logic                clr_all = 1'b0;
    logic                out_valid;
    logic [CW-1:0]       out_chan;
    logic signed [A-1:0] out_acc;
`ifdef MEALY_MAC_SAT_EN
    logic                out_sat;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mealy_mac_bank #(.WIDTH(W), .ACC_W(A), .CHANNELS(C)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_chan        (in_chan),
        .in_x           (in_x),
        .in_y           (in_y),
        .in_clr         (in_clr),
        .clr_all        (clr_all),
        .out_valid      (out_valid),
        .out_chan       (out_chan),
`ifdef MEALY_MAC_SAT_EN
        .out_sat        (out_sat),
`endif
        .out_acc        (out_acc)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input int ch, input int x, input int y,
                        input bit clr, input longint exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_chan  = CW'(ch);
        in_x     = W'(x);
        in_y     = W'(y);
        in_clr   = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_clr   = 1'b0;
        chk({tag, "_valid"}, longint'(out_valid), 1);
        chk({tag, "_chan"}, longint'(out_chan), ch);
        chk({tag, "_acc"}, longint'(out_acc), exp);
    endtask

    initial begin
        int  n;
        bit  saw_valid;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_acc", longint'(out_acc), 0);
        chk("rst_chan", longint'(out_chan), 0);
        chk("rst_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Accumulate on ch1: 12, 12-10=2, 2+49=51
        beat("acc1", 1, 3, 4, 0, 0);
        beat("acc2", 1, -2, 5, 0, 12);
        beat("acc3", 1, 7, 7, 0, 2);
        beat("acc4", 1, 1, 1, 0, 51);

        // Isolation and per-channel clear
        beat("iso0", 0, 10, 10, 0, 0);
        beat("iso2", 2, 1, 1, 0, 0);
        beat("clr0", 0, 2, 3, 1, 100);
        beat("iso2b", 2, 1, 1, 0, 1);
        beat("aft0", 0, 0, 0, 0, 6);

        // Out-of-range channel is accepted but dropped
        @(negedge clk);
        in_valid = 1'b1;
        in_chan  = 2'd3;
        in_x     = 9'sd5;
        in_y     = 9'sd5;
        chk("bad_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bad_valid", longint'(out_valid), 0);
        beat("bad_c0", 0, 0, 0, 0, 6);
        beat("bad_c1", 1, 0, 0, 0, 52);
        beat("bad_c2", 2, 0, 0, 0, 2);

        // Sweep: beat in the clr_all cycle is processed, clr_all held one extra cycle is ignored,
        // and a beat held through the sweep is accepted only afterwards.
        @(negedge clk);
        clr_all  = 1'b1;
        in_valid = 1'b1;
        in_chan  = 2'd0;
        in_x     = 9'sd1;
        in_y     = 9'sd1;
        @(posedge clk);
        #1;
        chk("swp_beat_valid", longint'(out_valid), 1);
        chk("swp_beat_acc", longint'(out_acc), 6);
        n = 0;
        saw_valid = 1'b0;
        while (in_ready === 1'b0 && n < 20) begin
            n++;
            if (n > 1 && out_valid !== 1'b0) saw_valid = 1'b1;
            @(posedge clk);
            #1;
            clr_all = 1'b0;
        end
        chk("swp_len", n, C);
        chk("swp_quiet", longint'(saw_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("held_valid", longint'(out_valid), 1);
        chk("held_acc", longint'(out_acc), 0);
        beat("swp_c1", 1, 0, 0, 0, 0);
        beat("swp_c2", 2, 0, 0, 0, 0);
        beat("swp_c0", 0, 0, 0, 0, 1);

        // Overflow: 65536 per beat, top of 18-bit range is 131071
        beat("ovf1", 2, -256, -256, 0, 0);
`ifdef MEALY_MAC_SAT_EN
        chk("ovf1_sat", longint'(out_sat), 0);
        beat("ovf2", 2, -256, -256, 0, 65536);
        chk("ovf2_sat", longint'(out_sat), 1);
        beat("ovf3", 2, -256, -256, 0, 131071);
        chk("ovf3_sat", longint'(out_sat), 1);
`else
        beat("ovf2", 2, -256, -256, 0, 65536);
        beat("ovf3", 2, -256, -256, 0, -131072);
        beat("ovf4", 2, 0, 0, 0, -65536);
`endif

        // Reset mid-stream aborts the pending beat and clears the bank
        beat("pre_rst", 1, 5, 5, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_chan  = 2'd1;
        in_x     = 9'sd1;
        in_y     = 9'sd1;
        rst      = 1'b1;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_acc", longint'(out_acc), 0);
        chk("mid_rst_ready", longint'(in_ready), 1);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        beat("post_rst_c1", 1, 0, 0, 0, 0);
        beat("post_rst_c0", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
